// File: rtl/regbank16x32.sv
// 16 x WIDTH register bank: one synchronous write port, two combinational
// read ports, and a sequenced bulk-clear engine (IDLE/CLEAR).
// Optional macro REGBANK_BYPASS_EN enables same-cycle write-through
// forwarding onto the read ports.
module regbank16x32 #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          ZERO_REG0 = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [3:0]       raddr_a,
    input  logic [3:0]       raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_req,
    output logic             busy,
    output logic             wr_drop
);

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             wr_drop_q, wr_drop_d;
    logic [WIDTH-1:0] entries_q [DEPTH];
    logic [WIDTH-1:0] entries_d [DEPTH];
    logic             wr_blocked;

    // Writes to the hardwired-zero entry are silently ignored (no drop pulse).
    assign wr_blocked = ZERO_REG0 && (waddr == '0);
    assign busy       = (state_q == CLEAR);
    assign wr_drop    = wr_drop_q;

    // Next-state: write commit in IDLE, one-entry-per-cycle sweep in CLEAR.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_drop_d = 1'b0;
        entries_d = entries_q;
        case (state_q)
            IDLE: begin
                if (we && !wr_blocked) begin
                    entries_d[waddr] = wdata;
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                entries_d[ptr_q] = '0;
                if (we && !wr_blocked) begin
                    wr_drop_d = 1'b1;
                end
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // State, pointer, drop flag and storage registers; reset wins over all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wr_drop_d;
            entries_q <= entries_d;
        end
    end

    // Read port A: stored word, optional forwarding, entry-0 override last.
    always_comb begin
        rdata_a = entries_q[raddr_a];
`ifdef REGBANK_BYPASS_EN
        if (we && !busy && !wr_blocked && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
`endif
        if (ZERO_REG0 && (raddr_a == '0)) begin
            rdata_a = '0;
        end
    end

    // Read port B: same selection as port A.
    always_comb begin
        rdata_b = entries_q[raddr_b];
`ifdef REGBANK_BYPASS_EN
        if (we && !busy && !wr_blocked && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
`endif
        if (ZERO_REG0 && (raddr_b == '0)) begin
            rdata_b = '0;
        end
    end

endmodule

// File: tb/tb_regbank16x32.sv
// Scoreboard bench for regbank16x32: two instances (ZERO_REG0 = 0 and 1)
// share the same stimulus; a reference model predicts every cycle's outputs.
module tb_regbank16x32;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr_a;
    logic [3:0]  raddr_b;
    logic        clr_req;

    logic [31:0] rda [2];
    logic [31:0] rdb [2];
    logic        bsy [2];
    logic        drp [2];

    always #5 clk = ~clk;

    regbank16x32 #(.WIDTH(32), .ZERO_REG0(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rda[0]), .rdata_b(rdb[0]),
        .clr_req(clr_req), .busy(bsy[0]), .wr_drop(drp[0])
    );

    regbank16x32 #(.WIDTH(32), .ZERO_REG0(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rda[1]), .rdata_b(rdb[1]),
        .clr_req(clr_req), .busy(bsy[1]), .wr_drop(drp[1])
    );

    typedef struct packed {
        logic [1:0][31:0] ra;
        logic [1:0][31:0] rb;
        logic [1:0]       busy;
        logic [1:0]       drop;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: word arrays, sweep cycles remaining, pending drop pulse.
    logic [31:0] mem [2][16];
    int          clr_left;
    logic        drop_pend [2];

    function automatic logic [31:0] model_rd(input int i, input logic [3:0] a);
        logic zr;
        zr = (i == 1);
        if (zr && a == 4'd0) return 32'h0;
`ifdef REGBANK_BYPASS_EN
        if (we && clr_left == 0 && a == waddr && !(zr && waddr == 4'd0)) return wdata;
`endif
        return mem[i][a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 16; k++) mem[i][k] = 32'h0;
                drop_pend[i] = 1'b0;
            end
            clr_left = 0;
        end else begin
            for (int i = 0; i < 2; i++)
                drop_pend[i] = we && (clr_left > 0) && !(i == 1 && waddr == 4'd0);
            if (clr_left == 0) begin
                for (int i = 0; i < 2; i++)
                    if (we && !(i == 1 && waddr == 4'd0)) mem[i][waddr] = wdata;
                if (clr_req) clr_left = 16;
            end else begin
                for (int i = 0; i < 2; i++) mem[i][16 - clr_left] = 32'h0;
                clr_left = clr_left - 1;
            end
        end
    endtask

    // Apply one cycle of inputs, queue the predicted outputs, advance model.
    task automatic cyc(input logic r, input logic w, input logic [3:0] wa,
                       input logic [31:0] wd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic cr, input bit chk);
        exp_t e;
        rst = r; we = w; waddr = wa; wdata = wd;
        raddr_a = ra; raddr_b = rb; clr_req = cr;
        if (chk) begin
            for (int i = 0; i < 2; i++) begin
                e.ra[i]   = model_rd(i, ra);
                e.rb[i]   = model_rd(i, rb);
                e.busy[i] = (clr_left > 0);
                e.drop[i] = drop_pend[i];
            end
            exp_q.push_back(e);
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, inst, $time, act, req);
        end
    endtask

    // Monitor: compares live DUT outputs mid-cycle against the queued prediction.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < 2; i++) begin
                check("rdata_a", i, rda[i], e.ra[i]);
                check("rdata_b", i, rdb[i], e.rb[i]);
                check("busy",    i, 32'(bsy[i]), 32'(e.busy[i]));
                check("wr_drop", i, 32'(drp[i]), 32'(e.drop[i]));
            end
        end
    end

    initial begin
        int drain;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) mem[i][k] = 32'h0;
            drop_pend[i] = 1'b0;
        end
        clr_left = 0;
        repeat (2) @(posedge clk);
        #1;

        // Post-reset: every address reads zero on both ports.
        for (int k = 0; k < 16; k++)
            cyc(0, 0, 0, 0, 4'(k), 4'(15 - k), 0, 1);

        // Basic writes then reads.
        cyc(0, 1, 4'd2,  32'h1,   0, 0, 0, 1);
        cyc(0, 1, 4'd1,  32'h5,   0, 0, 0, 1);
        cyc(0, 1, 4'd15, 32'hAAA, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 4'd2, 4'd15, 0, 1);
        cyc(0, 0, 0, 0, 4'd1, 4'd2,  0, 1);

        // Same-cycle read of the entry being written.
        cyc(0, 1, 4'd3, 32'hDEADBEEF, 4'd3, 4'd3, 0, 1);
        cyc(0, 0, 0, 0, 4'd3, 4'd3, 0, 1);

        // Fill with index, clear, re-request mid-sweep, drop a write mid-sweep.
        for (int k = 0; k < 16; k++)
            cyc(0, 1, 4'(k), 32'(k), 4'(k), 4'(15 - k), 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        for (int j = 0; j < 19; j++)
            cyc(0, (j == 6), 4'd9, 32'hFFFF, 4'(j), 4'(j + 1), (j == 3), 1);

        // Write to entry 0: visible on instance 0, ignored on instance 1.
        cyc(0, 1, 4'd0, 32'hFFFFFFFF, 4'd0, 4'd0, 0, 1);
        cyc(0, 0, 0, 0, 4'd0, 4'd0, 0, 1);

        // Refill, start clear, reset on its fifth busy cycle, then full re-sweep.
        for (int k = 0; k < 16; k++)
            cyc(0, 1, 4'(k), 32'(k) + 32'h100, 4'(k), 4'(k), 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        for (int j = 0; j < 4; j++) cyc(0, 0, 0, 0, 4'(j), 4'(15 - j), 0, 1);
        cyc(1, 0, 0, 0, 4'd10, 4'd11, 0, 1);
        for (int k = 0; k < 16; k++) cyc(0, 0, 0, 0, 4'(k), 4'(15 - k), 0, 1);
        for (int k = 0; k < 16; k++)
            cyc(0, 1, 4'(k), 32'hC0DE0000 + 32'(k), 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        for (int j = 0; j < 18; j++) cyc(0, 0, 0, 0, 4'(j), 4'(15 - j), 0, 1);

        // Randomised traffic.
        for (int n = 0; n < 400; n++)
            cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 15)), $urandom,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 24) == 0), 1);

        drain = 0;
        while (exp_q.size() > 0 && drain < 5) begin
            @(posedge clk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regbank16x32.md
Name: regbank16x32

Overview:
- 16-entry x 32-bit register bank with one synchronous write port and two combinational read ports.
- Sits directly upstream of the 16:1 32-bit mux stage. The bank holds the 16 word sources, and each read port performs the 4-bit-select word selection that feeds the operand path.
- Adds a sequenced bulk-clear engine so software/control can zero the bank without a global reset.

Parameters:
- WIDTH, 32, data word width in bits.
- ZERO_REG0, 0, when 1: entry 0 reads as all-zeros and ignores writes.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable, sampled on rising clk.
- waddr  input  4  write entry index.
- wdata  input  WIDTH  write data.
- raddr_a  input  4  read port A entry index.
- raddr_b  input  4  read port B entry index.
- rdata_a  output  WIDTH  port A read data (combinational).
- rdata_b  output  WIDTH  port B read data (combinational).
- clr_req  input  1  single-cycle request to start a bulk clear.
- busy  output  1  high while a bulk clear is in progress.
- wr_drop  output  1  registered one-cycle pulse: a write was discarded because busy was high.

Behaviour:
- Reset (rst=1 at rising clk):
  - All 16 entries <= 0; FSM <= IDLE; clear pointer <= 0.
  - busy=0, wr_drop=0.
  - Reset has priority over every other input, including mid-clear; an in-progress clear is aborted (entries end up zero anyway).
- Reads:
  - Purely combinational: rdata_x = entry[raddr_x].
  - A write at edge N is visible on the read ports after edge N. No same-cycle forwarding unless the optional feature is enabled.
  - With ZERO_REG0=1, raddr_x=0 returns 0 regardless of stored content.
- Writes:
  - Occur when we=1 and busy=0 at the rising edge: entry[waddr] <= wdata. Latency 1 cycle.
  - With ZERO_REG0=1, a write to entry 0 has no effect and does not raise wr_drop.
  - we=1 while busy=1: write discarded; wr_drop=1 for the following cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_req=1 -> CLEAR; pointer <= 0. busy rises the cycle after the request edge.
  - CLEAR: each edge does entry[pointer] <= 0 and pointer <= pointer+1.
  - CLEAR exit: when pointer==15 is cleared, return to IDLE; busy falls on that same edge.
  - busy is high for exactly 16 cycles per clear.
  - clr_req while in CLEAR is ignored; no restart and no queueing.
- Simultaneous events:
  - clr_req=1 and we=1 in IDLE on the same edge: the write commits (busy still 0) and is erased later by the sweep.
  - Pointer wraps only via the FSM exit; no other wrap-around exists.
- Read ports stay live during CLEAR and show each entry zeroing progressively.

Optional Feature:
- Macro REGBANK_BYPASS_EN.
- Defined: if we=1, busy=0 and raddr_x==waddr (and not the ZERO_REG0 entry-0 case), rdata_x = wdata combinationally in the same cycle (write-through forwarding).
- Undefined: no forwarding; reads return the pre-write stored value until the next edge.

Test Plan:
- Reset then read all 16 addresses on both ports -> every read = 32'h0, busy=0, wr_drop=0.
- Write 32'h1 to entry 2, 32'h5 to entry 1, 32'hAAA to entry 15; then raddr_a=2, raddr_b=15 -> rdata_a=32'h1, rdata_b=32'hAAA; raddr_a=1 -> 32'h5.
- Same-cycle: we=1, waddr=3, wdata=32'hDEADBEEF, raddr_a=3 -> rdata_a=old value (0) without REGBANK_BYPASS_EN; 32'hDEADBEEF with it; both show 32'hDEADBEEF next cycle.
- Fill all entries with their index, pulse clr_req -> busy high exactly 16 cycles; entry k reads 0 from cycle k+2 after the request edge; a write issued mid-clear is dropped with a wr_drop pulse and no entry changes.
- ZERO_REG0=1: write 32'hFFFFFFFF to entry 0 -> rdata_a(raddr_a=0)=0, wr_drop stays 0.
- Assert rst at cycle 5 of a clear -> next cycle busy=0, FSM IDLE, all entries 0; a new clr_req then restarts a full 16-cycle sweep.
